imem_port_arb: RTL and testbench
================================

// Module: imem_port_arb
// PURPOSE
//   Shares the single, combinational-read instruction ROM port between two requesters:
//   - instruction fetch (IF);
//   - MEM-stage loads that read constants from code space.
//   Grants at most one requester per cycle, drives the ROM ce/addr and registers the returned word.
//   Sits between pc_reg/IF, MEM and inst_rom; requests IF stall while IF is denied.
// PARAMETERS
//   ADDR_W      32  byte-address width of both requesters and the ROM port
//   DATA_W      32  instruction/data word width
//   STARVE_MAX  4   consecutive contended IF denials before IF is forced to win (>=1)
// PORTS
//   clk          in   1       system clock, all state on rising edge
//   rst          in   1       asynchronous, active-low reset (0 = reset)
//   if_req       in   1       IF requests a fetch this cycle
//   if_addr      in   ADDR_W  IF byte address (word aligned by construction)
//   if_flush     in   1       branch/exception flush: discard IF response of this cycle's grant
//   if_gnt       out  1       IF request accepted this cycle (combinational)
//   if_rvalid    out  1       IF response valid (registered)
//   if_rdata     out  DATA_W  IF instruction word
//   stallreq_if  out  1       if_req & ~if_gnt, to ctrl (combinational)
//   mem_req      in   1       MEM requests a code-space read
//   mem_addr     in   ADDR_W  MEM byte address
//   mem_gnt      out  1       MEM request accepted this cycle (combinational)
//   mem_rvalid   out  1       MEM response valid (registered)
//   mem_rdata    out  DATA_W  MEM read word
//   mem_err      out  1       qualifies mem_rvalid: misaligned address, mem_rdata=0
//   rom_ce       out  1       ROM chip enable (`ChipEna/`ChipDisa)
//   rom_addr     out  ADDR_W  ROM byte address, from granted requester
//   rom_inst     in   DATA_W  ROM read word, valid same cycle as rom_addr
// BEHAVIOUR
//   - Reset (rst=0, async): all rvalid/err/rdata=0, starve_cnt=0, last_win=IF. Combinational
//     outputs (gnt/stallreq/rom_*) stay 0/`ChipDisa; req is qualified with rst.
//   - Grant, single requester: that requester is granted in the same cycle.
//   - Grant, both requesting: MEM wins (older instruction), unless starve_cnt==STARVE_MAX,
//     then IF wins. No request: rom_ce=`ChipDisa, rom_addr=0.
//   - starve_cnt: +1 per cycle of if_req&mem_req with MEM winning, saturating at STARVE_MAX.
//     Cleared when IF is granted or if_req=0.
//   - Datapath: rom_ce=`ChipEna, rom_addr=granted addr, same cycle.
//   - Latency: exactly 1 cycle. Grant in cycle N -> rvalid=1, rdata=rom_inst sampled at edge
//     end of N, visible in N+1. rvalid is a 1-cycle pulse; back-to-back grants give
//     back-to-back responses. rdata holds its last value while rvalid=0.
//   - No back-pressure on responses: requesters must accept them.
//   - MEM misaligned (mem_addr[1:0]!=0): granted normally, but rom_ce=`ChipDisa and the
//     ROM port stays free that cycle, so IF may be granted in the same cycle.
//     N+1: mem_rvalid=1, mem_err=1, mem_rdata=0.
//   - if_flush=1 in cycle N with IF granted: ROM is still accessed, if_rvalid=0 in N+1,
//     if_rdata unchanged. Flush never affects the MEM path or a response already visible in N.
//   - Reset asserted mid-transaction: pending response dropped, no rvalid after release.
// CONFIGURATION
//   IMEM_ARB_RR_EN
//   - Defined: contention resolved round-robin via last_win flop (loser of last contention wins
//     next); starve counter and STARVE_MAX unused; first contention after reset goes to MEM.
//   - Undefined: fixed MEM priority + starvation counter as above.
// STRUCTURE
//   - define.v: `ChipEna/`ChipDisa, `ZeroWord, `InstBus, `InstAddrBus reused;
//     add `ArbIF=1'b0, `ArbMEM=1'b1 winner encodings.
//   - One sub-module: imem_arb_pick (combinational winner select from reqs, starve_cnt/last_win).
//   - Response registers and counter live in imem_port_arb.
// TESTING
//   1. rst=0 with both reqs=1 -> all gnt/rvalid=0, rom_ce=`ChipDisa; release -> clean start.
//   2. IF only, if_addr=0x0000_0004, rom word 0x3401_1100 -> if_gnt same cycle, rom_addr=4;
//      next cycle if_rvalid=1, if_rdata=0x3401_1100.
//   3. Both req every cycle, STARVE_MAX=4 -> grants M,M,M,M,I repeating;
//      stallreq_if=1 on M cycles. RR build: M,I,M,I.
//   4. mem_addr=0x0000_0006 alone -> mem_gnt=1, rom_ce=`ChipDisa;
//      next cycle mem_rvalid=1, mem_err=1, mem_rdata=0.
//   5. IF granted at 0x8 with if_flush=1 -> no if_rvalid next cycle. MEM response in the
//      same window (granted in an adjacent cycle, e.g. MEM misaligned + IF in one cycle)
//      is delivered intact.
//   6. rst pulled low between grant and next edge -> rvalid stays 0, no response after release.

Source files
------------

// File: rtl/imem_port_arb_pkg.sv
// Shared types and constants for the instruction-ROM port arbiter.
// Holds the winner encoding, the ROM chip-enable levels and the alignment helper.
package imem_port_arb_pkg;

    typedef enum logic {
        ARB_IF  = 1'b0,
        ARB_MEM = 1'b1
    } arb_win_e;

    localparam logic CHIP_ENA  = 1'b1;
    localparam logic CHIP_DISA = 1'b0;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return (lsb != 2'b00);
    endfunction

endpackage

// File: rtl/imem_arb_pick.sv
// Combinational winner select for the shared ROM port.
// A misaligned MEM access never occupies the ROM, so it cannot contend with IF.
module imem_arb_pick
    import imem_port_arb_pkg::*;
(
    input  logic     if_req_i,
    input  logic     mem_req_i,
    input  logic     mem_mis_i,
    input  logic     if_pri_i,
    output logic     if_gnt_o,
    output logic     mem_gnt_o,
    output logic     contend_o,
    output arb_win_e rom_win_o
);

    always_comb begin
        contend_o = if_req_i & mem_req_i & ~mem_mis_i;
        mem_gnt_o = mem_req_i & ~(contend_o & if_pri_i);
        if_gnt_o  = if_req_i & (~contend_o | if_pri_i);
        rom_win_o = (mem_gnt_o & ~mem_mis_i) ? ARB_MEM : ARB_IF;
    end

endmodule

// File: rtl/imem_port_arb.sv
// Shares the combinational instruction ROM between IF fetches and MEM constant loads.
// Build option IMEM_ARB_RR_EN: round-robin contention instead of MEM priority + starvation limit.
module imem_port_arb
    import imem_port_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              stallreq_if,
    input  logic              mem_req,
    input  logic [ADDR_W-1:0] mem_addr,
    output logic              mem_gnt,
    output logic              mem_rvalid,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_err,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_inst
);

    logic     if_req_v;
    logic     mem_req_v;
    logic     mem_mis;
    logic     if_pri;
    logic     contend;
    arb_win_e rom_win;

    logic              if_rvalid_q,  if_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q,   if_rdata_d;
    logic              mem_rvalid_q, mem_rvalid_d;
    logic              mem_err_q,    mem_err_d;
    logic [DATA_W-1:0] mem_rdata_q,  mem_rdata_d;

    // Requests are masked during reset so the ROM port and grants stay idle.
    assign if_req_v  = if_req & rst;
    assign mem_req_v = mem_req & rst;
    assign mem_mis   = is_misaligned(mem_addr[1:0]);

    imem_arb_pick u_pick (
        .if_req_i  (if_req_v),
        .mem_req_i (mem_req_v),
        .mem_mis_i (mem_mis),
        .if_pri_i  (if_pri),
        .if_gnt_o  (if_gnt),
        .mem_gnt_o (mem_gnt),
        .contend_o (contend),
        .rom_win_o (rom_win)
    );

`ifdef IMEM_ARB_RR_EN
    arb_win_e last_win_q, last_win_d;

    assign if_pri = (last_win_q == ARB_MEM);

    always_comb begin
        last_win_d = last_win_q;
        if (contend) begin
            last_win_d = if_gnt ? ARB_IF : ARB_MEM;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_win_q <= ARB_IF;
        end else begin
            last_win_q <= last_win_d;
        end
    end
`else
    localparam int SCW = $clog2(STARVE_MAX + 1);
    localparam logic [SCW-1:0] STARVE_LIM = SCW'(STARVE_MAX);

    logic [SCW-1:0] starve_cnt_q, starve_cnt_d;

    assign if_pri = (starve_cnt_q == STARVE_LIM);

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!if_req_v || if_gnt) begin
            starve_cnt_d = '0;
        end else if (contend && mem_gnt && (starve_cnt_q != STARVE_LIM)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`endif

    always_comb begin
        rom_ce   = CHIP_DISA;
        rom_addr = '0;
        if (mem_gnt && !mem_mis) begin
            rom_ce   = CHIP_ENA;
            rom_addr = mem_addr;
        end else if (if_gnt) begin
            rom_ce   = CHIP_ENA;
            rom_addr = if_addr;
        end
    end

    assign stallreq_if = if_req_v & ~if_gnt;

    always_comb begin
        if_rvalid_d  = if_gnt & ~if_flush;
        if_rdata_d   = if_rdata_q;
        mem_rvalid_d = mem_gnt;
        mem_err_d    = mem_gnt & mem_mis;
        mem_rdata_d  = mem_rdata_q;
        // A flushed fetch still reads the ROM but leaves the old word on if_rdata.
        if (if_gnt && !if_flush && rom_win == ARB_IF) begin
            if_rdata_d = rom_inst;
        end
        if (mem_gnt) begin
            mem_rdata_d = mem_mis ? '0 : rom_inst;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_rvalid_q  <= 1'b0;
            if_rdata_q   <= '0;
            mem_rvalid_q <= 1'b0;
            mem_err_q    <= 1'b0;
            mem_rdata_q  <= '0;
        end else begin
            if_rvalid_q  <= if_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            mem_rvalid_q <= mem_rvalid_d;
            mem_err_q    <= mem_err_d;
            mem_rdata_q  <= mem_rdata_d;
        end
    end

    assign if_rvalid  = if_rvalid_q;
    assign if_rdata   = if_rdata_q;
    assign mem_rvalid = mem_rvalid_q;
    assign mem_err    = mem_err_q;
    assign mem_rdata  = mem_rdata_q;

endmodule

// File: tb/tb_imem_port_arb.sv
// Directed bench for imem_port_arb with a combinational ROM model.
// Expected grant pattern follows IMEM_ARB_RR_EN when the bench is built with it.
module tb_imem_port_arb;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        stallreq_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_err;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;

    int n_tests = 0;
    int n_fail  = 0;

    imem_port_arb #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_flush    (if_flush),
        .if_gnt      (if_gnt),
        .if_rvalid   (if_rvalid),
        .if_rdata    (if_rdata),
        .stallreq_if (stallreq_if),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .mem_err     (mem_err),
        .rom_ce      (rom_ce),
        .rom_addr    (rom_addr),
        .rom_inst    (rom_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a == 32'h0000_0004) return 32'h3401_1100;
        return {16'hC0DE, a[15:0]};
    endfunction

    assign rom_inst = rom_word(rom_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic fl,
                         input logic mr, input logic [31:0] ma);
        if_req   = ir;
        if_addr  = ia;
        if_flush = fl;
        mem_req  = mr;
        mem_addr = ma;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    logic [9:0] exp_mem_win;
    logic       prev_mem;

    initial begin
`ifdef IMEM_ARB_RR_EN
        exp_mem_win = 10'b01_0101_0101;
`else
        exp_mem_win = 10'b01_1110_1111;
`endif
        rst = 1'b0;
        drive(1'b1, 32'h40, 1'b0, 1'b1, 32'h80);
        #3;
        chk("rst_if_gnt",   {31'b0, if_gnt},      32'd0);
        chk("rst_mem_gnt",  {31'b0, mem_gnt},     32'd0);
        chk("rst_rom_ce",   {31'b0, rom_ce},      32'd0);
        chk("rst_rom_addr", rom_addr,             32'd0);
        chk("rst_stall",    {31'b0, stallreq_if}, 32'd0);
        step();
        step();
        chk("rst_if_rv",    {31'b0, if_rvalid},   32'd0);
        chk("rst_mem_rv",   {31'b0, mem_rvalid},  32'd0);
        chk("rst_if_rd",    if_rdata,             32'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("rel_if_rv",    {31'b0, if_rvalid},   32'd0);
        chk("rel_mem_rv",   {31'b0, mem_rvalid},  32'd0);

        // IF alone
        drive(1'b1, 32'h4, 1'b0, 1'b0, 32'h0);
        #1;
        chk("t2_if_gnt",   {31'b0, if_gnt},      32'd1);
        chk("t2_rom_ce",   {31'b0, rom_ce},      32'd1);
        chk("t2_rom_addr", rom_addr,             32'h4);
        chk("t2_stall",    {31'b0, stallreq_if}, 32'd0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("t2_if_rv",    {31'b0, if_rvalid},   32'd1);
        chk("t2_if_rd",    if_rdata,             32'h3401_1100);
        chk("t2_mem_rv",   {31'b0, mem_rvalid},  32'd0);
        step();
        chk("t2_if_rv_off", {31'b0, if_rvalid},  32'd0);
        chk("t2_if_rd_hold", if_rdata,           32'h3401_1100);

        // Both requesting every cycle
        prev_mem = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h10, 1'b0, 1'b1, 32'h20);
            #1;
            chk($sformatf("t3_mem_gnt%0d", i), {31'b0, mem_gnt},     {31'b0, exp_mem_win[i]});
            chk($sformatf("t3_if_gnt%0d", i),  {31'b0, if_gnt},      {31'b0, ~exp_mem_win[i]});
            chk($sformatf("t3_stall%0d", i),   {31'b0, stallreq_if}, {31'b0, exp_mem_win[i]});
            chk($sformatf("t3_addr%0d", i),    rom_addr, exp_mem_win[i] ? 32'h20 : 32'h10);
            prev_mem = exp_mem_win[i];
            step();
            chk($sformatf("t3_mem_rv%0d", i), {31'b0, mem_rvalid}, {31'b0, prev_mem});
            chk($sformatf("t3_if_rv%0d", i),  {31'b0, if_rvalid},  {31'b0, ~prev_mem});
        end
        chk("t3_mem_rd", mem_rdata, 32'hC0DE_0020);
        chk("t3_if_rd",  if_rdata,  32'hC0DE_0010);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step();

        // MEM misaligned alone
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h6);
        #1;
        chk("t4_mem_gnt",  {31'b0, mem_gnt}, 32'd1);
        chk("t4_rom_ce",   {31'b0, rom_ce},  32'd0);
        chk("t4_rom_addr", rom_addr,         32'd0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("t4_mem_rv",  {31'b0, mem_rvalid}, 32'd1);
        chk("t4_mem_err", {31'b0, mem_err},    32'd1);
        chk("t4_mem_rd",  mem_rdata,           32'd0);
        step();
        chk("t4_mem_rv_off", {31'b0, mem_rvalid}, 32'd0);

        // Flushed IF alongside a misaligned MEM, then an aligned MEM read
        drive(1'b1, 32'h8, 1'b1, 1'b1, 32'h6);
        #1;
        chk("t5_if_gnt",   {31'b0, if_gnt},  32'd1);
        chk("t5_mem_gnt",  {31'b0, mem_gnt}, 32'd1);
        chk("t5_rom_ce",   {31'b0, rom_ce},  32'd1);
        chk("t5_rom_addr", rom_addr,         32'h8);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h24);
        chk("t5_if_rv",   {31'b0, if_rvalid},  32'd0);
        chk("t5_if_rd",   if_rdata,            32'hC0DE_0010);
        chk("t5_mem_rv",  {31'b0, mem_rvalid}, 32'd1);
        chk("t5_mem_err", {31'b0, mem_err},    32'd1);
        chk("t5_mem_rd0", mem_rdata,           32'd0);
        step();
        drive(1'b1, 32'h8, 1'b0, 1'b0, 32'h0);
        chk("t5_mem_rv2",  {31'b0, mem_rvalid}, 32'd1);
        chk("t5_mem_err2", {31'b0, mem_err},    32'd0);
        chk("t5_mem_rd",   mem_rdata,           32'hC0DE_0024);
        chk("t5_if_rv2",   {31'b0, if_rvalid},  32'd0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("t5_if_rv3", {31'b0, if_rvalid}, 32'd1);
        chk("t5_if_rd3", if_rdata,           32'hC0DE_0008);

        // Reset between grant and the next edge
        drive(1'b1, 32'hC, 1'b0, 1'b1, 32'h30);
        #1;
        chk("t6_pre_gnt", {31'b0, mem_gnt}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("t6_gnt_off", {31'b0, mem_gnt}, 32'd0);
        chk("t6_ce_off",  {31'b0, rom_ce},  32'd0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("t6_if_rv",  {31'b0, if_rvalid},  32'd0);
        chk("t6_mem_rv", {31'b0, mem_rvalid}, 32'd0);
        chk("t6_mem_rd", mem_rdata,           32'd0);
        step();
        chk("t6_mem_rv2", {31'b0, mem_rvalid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
